// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Largest legal value of a single BCD digit
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Smallest width that can hold 10**digits-1, i.e. ceil(log2(10**digits)).
  // Used at elaboration time to reject an undersized result width.
  function automatic int bin_width(input int digits);
    longint unsigned limit;
    int              width;
    limit = 64'd1;
    for (int i = 0; i < digits; i++) begin
      limit = limit * 64'd10;
    end
    width = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < limit) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/bcd_to_binary_step.sv
// One fold step of the converter: acc*10 + nibble, plus a flag for a non-decimal nibble.
module bcd_to_binary_step
  import bcd_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       nibble_i,
  output logic [ACC_W-1:0] acc_next_o,
  output logic             nibble_err_o
);

  // Multiply by ten as (acc<<3)+(acc<<1) so no multiplier is inferred, then add the digit
  always_comb begin
    acc_next_o   = (acc_i << 3) + (acc_i << 1) + {{(ACC_W-4){1'b0}}, nibble_i};
    nibble_err_o = (nibble_i > BCD_MAX);
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Multi-cycle packed-BCD to binary converter. Folds one digit per cycle,
// most significant digit first, behind a valid/ready handshake on both sides.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_err
);

  // Four spare bits keep illegal nibbles from wrapping the accumulator silently
  localparam int ACC_W = BIN_W + 4;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  if (DIGITS < 1) begin : gen_bad_digits
    $error("bcd_to_binary_seq: DIGITS must be at least 1");
  end
  if (BIN_W < bin_width(DIGITS)) begin : gen_bad_bin_w
    $error("bcd_to_binary_seq: BIN_W too small for 10**DIGITS-1");
  end

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   shiftReg_q, shiftReg_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [BIN_W-1:0]      outBin_q, outBin_d;
  logic                  outErr_q, outErr_d;

  logic [ACC_W-1:0]      stepAcc;
  logic                  stepErr;
  logic                  foldErr;

  bcd_to_binary_step #(
    .ACC_W (ACC_W)
  ) u_step (
    .acc_i        (acc_q),
    .nibble_i     (shiftReg_q[4*DIGITS-1 -: 4]),
    .acc_next_o   (stepAcc),
    .nibble_err_o (stepErr)
  );

  assign foldErr = err_q | stepErr;

  // Next-state and datapath update; everything holds unless the current state says otherwise
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    outBin_d   = outBin_q;
    outErr_d   = outErr_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = CONV;
          shiftReg_d = in_bcd;
          acc_d      = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
        end
      end
      CONV: begin
        acc_d      = stepAcc;
        shiftReg_d = shiftReg_q << 4;
        err_d      = foldErr;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          outErr_d = foldErr;
          outBin_d = foldErr ? '0 : stepAcc[BIN_W-1:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      outBin_q   <= '0;
      outErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      outBin_q   <= outBin_d;
      outErr_q   <= outErr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bin   = outBin_q;
  assign out_err   = outErr_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized self-checking bench for bcd_to_binary_seq against a digit-arithmetic model.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_bcd;
  logic              out_valid;
  logic              out_ready;
  logic [BIN_W-1:0]  out_bin;
  logic              out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Value of a packed BCD word as the weighted sum of its digits; any digit above 9 flags an error
  function automatic void refModel(input logic [15:0] word, output int value, output bit err);
    int weight;
    int digit;
    value  = 0;
    err    = 1'b0;
    weight = 1;
    for (int k = 0; k < DIGITS; k++) begin
      digit  = int'((word >> (4 * k)) & 16'hF);
      if (digit > 9) err = 1'b1;
      value  = value + digit * weight;
      weight = weight * 10;
    end
    if (err) value = 0;
  endfunction

  // Binary-to-BCD by repeated division, used for round-trip stimulus
  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] word;
    int          rest;
    word = '0;
    rest = v;
    for (int k = 0; k < DIGITS; k++) begin
      word[4*k +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return word;
  endfunction

  // Offer one word, scramble in_bcd during conversion, check result, hold it for a while, then release
  task automatic applyStimulus(input logic [15:0] word, input int holdCycles);
    int expValue;
    bit expErr;
    int waitCnt;
    int lat;
    refModel(word, expValue, expErr);
    waitCnt = 0;
    while (in_ready !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (in_ready !== 1'b1) begin
      checkOutput("inReadyTimeout", 32'(in_ready), 32'd1);
      return;
    end
    in_bcd   = word;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("busyInReady", 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      in_bcd = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(DIGITS));
    if (out_valid !== 1'b1) return;
    checkOutput("outBin", 32'(out_bin), 32'(expValue));
    checkOutput("outErr", 32'(out_err), 32'(expErr));
    for (int i = 0; i < holdCycles; i++) begin
      in_bcd = 16'($urandom);
      @(negedge clk);
      checkOutput("holdValid", 32'(out_valid), 32'd1);
      checkOutput("holdBin", 32'(out_bin), 32'(expValue));
      checkOutput("holdErr", 32'(out_err), 32'(expErr));
      checkOutput("holdInReady", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("releaseInReady", 32'(in_ready), 32'd1);
    checkOutput("releaseValid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_bcd    = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetInReady", 32'(in_ready), 32'd1);
    checkOutput("resetOutValid", 32'(out_valid), 32'd0);
    checkOutput("resetOutBin", 32'(out_bin), 32'd0);
    checkOutput("resetOutErr", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(16'h1234, 0);
    checkOutput("value1234", 32'(out_bin), 32'd1234);
    applyStimulus(16'h9999, 0);
    checkOutput("value9999", 32'(out_bin), 32'd9999);
    applyStimulus(16'h0000, 1);
    applyStimulus(16'h12A4, 0);
    checkOutput("errA", 32'(out_err), 32'd1);
    applyStimulus(16'h0042, 0);
    checkOutput("errCleared", 32'(out_err), 32'd0);
    applyStimulus(16'hF000, 0);
    applyStimulus(16'h000B, 2);
    applyStimulus(16'h3141, 5);

    // Abort a conversion with an asynchronous reset pulse
    in_bcd   = 16'h5678;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abortInReady", 32'(in_ready), 32'd1);
    checkOutput("abortOutValid", 32'(out_valid), 32'd0);
    checkOutput("abortOutBin", 32'(out_bin), 32'd0);
    checkOutput("abortOutErr", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0007, 0);
    checkOutput("afterAbort", 32'(out_bin), 32'd7);

    // Low end of the range exhaustively, then round trips of random integers
    for (int v = 0; v < 40; v++) begin
      applyStimulus(toBcd(v), 0);
    end
    for (int n = 0; n < 300; n++) begin
      applyStimulus(toBcd(int'($urandom_range(9999, 0))), int'($urandom_range(3, 0)));
    end
    // Raw random words, many of them containing illegal nibbles
    for (int n = 0; n < 100; n++) begin
      applyStimulus(16'($urandom), int'($urandom_range(2, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
